// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART byte transmitter with optional externally generated parity bit
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       parity_in,
    output logic       load_data,
    output logic [7:0] data_out,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic [7:0]    data_next;
    logic          baud_wrap;

    logic          tx_next;
    logic          busy_next;
    logic          load_next;
    logic          done_next;

    assign baud_wrap = (baud_cnt == CNT_LAST);

    // State, baud counter, bit index and frame byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            data_out  <= data_next;
        end
    end

    // Next-state logic: each non-idle state lasts one full baud period
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        data_next  = data_out;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_next = START;
                    cnt_next   = '0;
                    idx_next   = '0;
                    shift_next = tx_data;
                    data_next  = tx_data;
                end
            end
            START: begin
                if (baud_wrap) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs align with it
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        load_next = (state_next != IDLE);
        done_next = (state == STOP) && (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            // Capture parity once on entry and hold it for the whole bit
            PARITY:  tx_next = (state == PARITY) ? tx : parity_in;
            default: tx_next = 1'b1;
        endcase
    end

    // Registered serial line and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            load_data <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx        <= tx_next;
            tx_busy   <= busy_next;
            load_data <= load_next;
            tx_done   <= done_next;
        end
    end

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 1..65535).
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 inserts a parity bit between data and stop, 0 omits it.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data; level-sampled.
REQ-006 SHALL have port tx_data  input  8  byte to transmit; sampled only on the acceptance edge.
REQ-007 SHALL have port parity_in  input  1  parity bit returned by the external parity generator for data_out.
REQ-008 SHALL have port load_data  output  1  enable to the parity generator; high in every non-IDLE state.
REQ-009 SHALL have port data_out  output  8  latched frame byte presented to the parity generator.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, tx_start=1 at a rising edge SHALL be accepted: latch tx_data into data_out and the shift register, clear baud counter and bit index, go to START.
REQ-015 tx_start while not IDLE SHALL be ignored; no queuing.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1; each state bit lasts exactly CLKS_PER_BIT cycles; counter width ceil(log2(CLKS_PER_BIT)), minimum 1.
REQ-017 START: tx=0; after CLKS_PER_BIT cycles -> DATA.
REQ-018 DATA: tx=data_out[bit index], LSB first; bit index 0..7 advances at each baud-counter wrap; after bit 7 completes -> PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: tx=parity_in, registered when entering PARITY and held stable for the whole bit; after CLKS_PER_BIT cycles -> STOP.
REQ-020 STOP: tx=1; after CLKS_PER_BIT cycles -> IDLE.
REQ-021 tx, tx_busy, load_data SHALL be registered outputs (no combinational path from inputs).
REQ-022 tx_busy SHALL be 1 exactly in START, DATA, PARITY, STOP.
REQ-023 tx_done SHALL be 1 for exactly the first clock in IDLE after STOP, and 0 otherwise.
REQ-024 tx_start high during the tx_done cycle SHALL be accepted (back-to-back frames, no extra idle bit-time).
REQ-025 Frame length from the first tx=0 cycle to the last tx=1 stop cycle SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-026 data_out SHALL hold its value from acceptance until the next acceptance; tx_data changes mid-frame SHALL have no effect.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state IDLE, tx=1, tx_busy=0, tx_done=0, load_data=0, data_out=8'h00, and counters=0.
REQ-028 Reset mid-frame SHALL abort the frame with no tx_done pulse; the first edge after rst deasserts SHALL treat tx_start as in IDLE.

Verification
REQ-029 CLKS_PER_BIT=4, PARITY_EN=1, parity_in from an even-parity model, tx_data=8'hB5, tx_start pulsed at edge 0 -> tx=0 for cycles 1-4, then 1,0,1,0,1,1,0,1 at 4 cycles each, parity 1, stop 1; tx_done high on cycle 45 only.
REQ-030 Same setup, tx_data=8'h35 -> parity bit 0; tx_busy high for cycles 1-44 exactly.
REQ-031 PARITY_EN=0, CLKS_PER_BIT=1, tx_data=8'h01 -> tx sequence 0,1,0,0,0,0,0,0,0,1 over 10 cycles; tx_done on cycle 11.
REQ-032 tx_start held high continuously with two bytes (8'hA5, then 8'h3C presented at the tx_done cycle) -> second start bit immediately follows the first stop bit; no idle gap.
REQ-033 tx_start pulsed and tx_data changed mid-frame -> no effect on the frame in progress; data_out unchanged.
REQ-034 rst asserted between clock edges during DATA -> tx=1, tx_busy=0, load_data=0 asynchronously; no tx_done; a new frame after release transmits correctly.
